// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles,
// data-memory wait freezes with timeout halt, branch-taken flushes and a
// saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_RS,
  input  logic [4:0]       ID_RT,
  input  logic             ID_USE_RS,
  input  logic             ID_USE_RT,
  input  logic [4:0]       EX_RD,
  input  logic             EX_REGW,
  input  logic             EX_MEM2R,
  input  logic             BR_TAKEN,
  input  logic             DM_REQ,
  input  logic             DM_READY,
  output logic             PC_WR,
  output logic             IF_ID_WR,
  output logic             ID_EX_WR,
  output logic             EX_MEM_WR,
  output logic             MEM_WB_WR,
  output logic             IF_ID_FLUSH,
  output logic             ID_EX_FLUSH,
  output logic             MEM_ERR,
  output logic [CNT_W-1:0] STALL_CNT
);

  // wait_cnt only ever needs to reach MEM_TIMEOUT; with timeout disabled it may wrap harmlessly
  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_use;
  logic              freeze;
  logic              timeout_hit;

  // Hazard, freeze and timeout detection
  always_comb begin
    load_use    = EX_MEM2R && EX_REGW && (EX_RD != 5'd0) &&
                  ((ID_USE_RS && (ID_RS == EX_RD)) || (ID_USE_RT && (ID_RT == EX_RD)));
    freeze      = ((state == S_RUN) && DM_REQ && !DM_READY) ||
                  ((state == S_WAIT) && !DM_READY);
    timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_W'(MEM_TIMEOUT));
  end

  // Enables and flushes by priority: reset/halt > freeze > branch > load-use > normal
  always_comb begin
    PC_WR       = 1'b0;
    IF_ID_WR    = 1'b0;
    ID_EX_WR    = 1'b0;
    EX_MEM_WR   = 1'b0;
    MEM_WB_WR   = 1'b0;
    IF_ID_FLUSH = 1'b0;
    ID_EX_FLUSH = 1'b0;
    if (!rst || (state == S_HALT) || freeze) begin
      // everything held
    end else if (BR_TAKEN) begin
      PC_WR       = 1'b1;
      IF_ID_WR    = 1'b1;
      ID_EX_WR    = 1'b1;
      EX_MEM_WR   = 1'b1;
      MEM_WB_WR   = 1'b1;
      IF_ID_FLUSH = 1'b1;
      ID_EX_FLUSH = 1'b1;
    end else if (load_use) begin
      // hold PC and IF_ID, push a bubble into EX, let older instrs drain
      ID_EX_WR    = 1'b1;
      ID_EX_FLUSH = 1'b1;
      EX_MEM_WR   = 1'b1;
      MEM_WB_WR   = 1'b1;
    end else begin
      PC_WR       = 1'b1;
      IF_ID_WR    = 1'b1;
      ID_EX_WR    = 1'b1;
      EX_MEM_WR   = 1'b1;
      MEM_WB_WR   = 1'b1;
    end
  end

  // State machine, wait counter, sticky error and saturating stall counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_RUN;
      wait_cnt  <= '0;
      MEM_ERR   <= 1'b0;
      STALL_CNT <= '0;
    end else begin
      if (!PC_WR && (STALL_CNT != {CNT_W{1'b1}})) begin
        STALL_CNT <= STALL_CNT + CNT_W'(1);
      end
      case (state)
        S_RUN: begin
          if (DM_REQ && !DM_READY) begin
            state    <= S_WAIT;
            wait_cnt <= WAIT_W'(1);
          end
        end
        S_WAIT: begin
          if (DM_READY) begin
            state    <= S_RUN;
            wait_cnt <= '0;
          end else if (timeout_hit) begin
            state   <= S_HALT;
            MEM_ERR <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_HALT: begin
          // only reset leaves HALT
        end
        default: begin
          state    <= S_RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (timeout 4 / 16-bit counter and
// timeout disabled / 3-bit counter) share stimulus and are checked against a
// rule-level reference model.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, br_taken, dm_req, dm_ready, ex_regw, ex_mem2r, id_use_rs, id_use_rt;
  logic [4:0] id_rs, id_rt, ex_rd;

  logic        pc_wr_a, if_id_wr_a, id_ex_wr_a, ex_mem_wr_a, mem_wb_wr_a;
  logic        if_id_flush_a, id_ex_flush_a, mem_err_a;
  logic [15:0] stall_cnt_a;
  logic        pc_wr_b, if_id_wr_b, id_ex_wr_b, ex_mem_wr_b, mem_wb_wr_b;
  logic        if_id_flush_b, id_ex_flush_b, mem_err_b;
  logic [2:0]  stall_cnt_b;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .ID_RS(id_rs), .ID_RT(id_rt), .ID_USE_RS(id_use_rs),
    .ID_USE_RT(id_use_rt), .EX_RD(ex_rd), .EX_REGW(ex_regw), .EX_MEM2R(ex_mem2r),
    .BR_TAKEN(br_taken), .DM_REQ(dm_req), .DM_READY(dm_ready),
    .PC_WR(pc_wr_a), .IF_ID_WR(if_id_wr_a), .ID_EX_WR(id_ex_wr_a), .EX_MEM_WR(ex_mem_wr_a),
    .MEM_WB_WR(mem_wb_wr_a), .IF_ID_FLUSH(if_id_flush_a), .ID_EX_FLUSH(id_ex_flush_a),
    .MEM_ERR(mem_err_a), .STALL_CNT(stall_cnt_a)
  );

  pipe_hazard_ctrl #(.MEM_TIMEOUT(0), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .ID_RS(id_rs), .ID_RT(id_rt), .ID_USE_RS(id_use_rs),
    .ID_USE_RT(id_use_rt), .EX_RD(ex_rd), .EX_REGW(ex_regw), .EX_MEM2R(ex_mem2r),
    .BR_TAKEN(br_taken), .DM_REQ(dm_req), .DM_READY(dm_ready),
    .PC_WR(pc_wr_b), .IF_ID_WR(if_id_wr_b), .ID_EX_WR(id_ex_wr_b), .EX_MEM_WR(ex_mem_wr_b),
    .MEM_WB_WR(mem_wb_wr_b), .IF_ID_FLUSH(if_id_flush_b), .ID_EX_FLUSH(id_ex_flush_b),
    .MEM_ERR(mem_err_b), .STALL_CNT(stall_cnt_b)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: [0] = dut_a, [1] = dut_b
  int         to_v[2]  = '{4, 0};
  int         max_v[2] = '{65535, 7};
  int         m_halt[2], m_wait[2], m_wcnt[2], m_err[2], m_cnt[2];
  logic [6:0] exp_en[2];
  bit         pend = 1'b0;

  localparam logic [6:0] EN_NONE = 7'b0000000;
  localparam logic [6:0] EN_NORM = 7'b1111100;
  localparam logic [6:0] EN_BR   = 7'b1111111;
  localparam logic [6:0] EN_LU   = 7'b0011101;

  // Expected {PC,IF_ID,ID_EX,EX_MEM,MEM_WB,IF_ID_FLUSH,ID_EX_FLUSH} from the priority rules
  function automatic logic [6:0] rule_en(int k);
    logic lu;
    if (!rst) return EN_NONE;
    if (m_halt[k] != 0) return EN_NONE;
    if ((m_wait[k] != 0) ? !dm_ready : (dm_req && !dm_ready)) return EN_NONE;
    if (br_taken) return EN_BR;
    lu = ex_mem2r && ex_regw && (ex_rd != 5'd0) &&
         ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
    if (lu) return EN_LU;
    return EN_NORM;
  endfunction

  // Clock-edge update of the model using the inputs of the cycle just ended
  function automatic void step_model(int k);
    if (!rst) begin
      m_halt[k] = 0; m_wait[k] = 0; m_wcnt[k] = 0; m_err[k] = 0; m_cnt[k] = 0;
    end else begin
      if (!exp_en[k][6] && m_cnt[k] < max_v[k]) m_cnt[k]++;
      if (m_halt[k] == 0) begin
        if (m_wait[k] == 0) begin
          if (dm_req && !dm_ready) begin m_wait[k] = 1; m_wcnt[k] = 1; end
        end else if (dm_ready) begin
          m_wait[k] = 0; m_wcnt[k] = 0;
        end else if (to_v[k] != 0 && m_wcnt[k] == to_v[k]) begin
          m_halt[k] = 1; m_err[k] = 1; m_wait[k] = 0;
        end else begin
          m_wcnt[k]++;
        end
      end
    end
  endfunction

  function automatic logic [23:0] obs_a();
    return {pc_wr_a, if_id_wr_a, id_ex_wr_a, ex_mem_wr_a, mem_wb_wr_a,
            if_id_flush_a, id_ex_flush_a, mem_err_a, stall_cnt_a};
  endfunction
  function automatic logic [23:0] exp_a();
    return {exp_en[0], 1'(m_err[0]), 16'(m_cnt[0])};
  endfunction
  function automatic logic [10:0] obs_b();
    return {pc_wr_b, if_id_wr_b, id_ex_wr_b, ex_mem_wr_b, mem_wb_wr_b,
            if_id_flush_b, id_ex_flush_b, mem_err_b, stall_cnt_b};
  endfunction
  function automatic logic [10:0] exp_b();
    return {exp_en[1], 1'(m_err[1]), 3'(m_cnt[1])};
  endfunction

  // Apply one cycle of inputs after the falling edge and compute expectations
  task automatic drive(input logic r, input logic br, input logic req, input logic rdy,
                       input logic [4:0] rd, input logic regw, input logic m2r,
                       input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                       input logic urt);
    @(negedge clk);
    if (pend) begin
      step_model(0);
      step_model(1);
    end
    rst = r; br_taken = br; dm_req = req; dm_ready = rdy; ex_rd = rd; ex_regw = regw;
    ex_mem2r = m2r; id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
    #1;
    exp_en[0] = rule_en(0);
    exp_en[1] = rule_en(1);
    pend = 1'b1;
  endtask

  task automatic test_reset();
    logic [6:0] en;
    drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0);
    en = {pc_wr_a, if_id_wr_a, id_ex_wr_a, ex_mem_wr_a, mem_wb_wr_a, if_id_flush_a, id_ex_flush_a};
    checks++;
    if (en !== EN_NONE) begin errors++; $display("FAIL reset_en_a got %b exp %b", en, EN_NONE); end
    en = {pc_wr_b, if_id_wr_b, id_ex_wr_b, ex_mem_wr_b, mem_wb_wr_b, if_id_flush_b, id_ex_flush_b};
    checks++;
    if (en !== EN_NONE) begin errors++; $display("FAIL reset_en_b got %b exp %b", en, EN_NONE); end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    checks++;
    if (obs_a() !== exp_a()) begin errors++; $display("FAIL reset_a got %h exp %h", obs_a(), exp_a()); end
    checks++;
    if ({mem_err_a, stall_cnt_a} !== 17'd0) begin
      errors++; $display("FAIL reset_regs_a got %h exp 0", {mem_err_a, stall_cnt_a});
    end
  endtask

  task automatic test_normal();
    logic [4:0] rd;
    for (int i = 0; i < 20; i++) begin
      rd = 5'($urandom_range(1, 15));
      drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b1, rd, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 5'(rd + 5'd16), 1'b1, 5'(rd + 5'd16), 1'b1);
      checks++;
      if (obs_a() !== exp_a()) begin errors++; $display("FAIL normal_a cyc %0d got %h exp %h", i, obs_a(), exp_a()); end
      checks++;
      if ({pc_wr_a, if_id_wr_a, id_ex_wr_a, ex_mem_wr_a, mem_wb_wr_a, if_id_flush_a, id_ex_flush_a, stall_cnt_a} !== {EN_NORM, 16'd0}) begin
        errors++; $display("FAIL normal_const cyc %0d got %b cnt %0d", i, obs_a(), stall_cnt_a);
      end
    end
  endtask

  task automatic test_load_use();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 5'd2, 1'b1);
    checks++;
    if (obs_a() !== exp_a()) begin errors++; $display("FAIL lu_stall_a got %h exp %h", obs_a(), exp_a()); end
    checks++;
    if ({pc_wr_a, if_id_wr_a, id_ex_wr_a, ex_mem_wr_a, mem_wb_wr_a, if_id_flush_a, id_ex_flush_a} !== EN_LU) begin
      errors++; $display("FAIL lu_const got %h exp %b", obs_a(), EN_LU);
    end
    // load has moved to MEM: no hazard any more
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 5'd5, 1'b1, 5'd2, 1'b1);
    checks++;
    if (obs_a() !== exp_a()) begin errors++; $display("FAIL lu_after_a got %h exp %h", obs_a(), exp_a()); end
    checks++;
    if (stall_cnt_a !== 16'd1) begin errors++; $display("FAIL lu_cnt got %0d exp 1", stall_cnt_a); end
    // r0 destination, unused rs, and rt-match variants
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
    checks++;
    if (obs_a() !== exp_a()) begin errors++; $display("FAIL lu_r0_a got %h exp %h", obs_a(), exp_a()); end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 5'd3, 1'b1);
    checks++;
    if (obs_a() !== exp_a()) begin errors++; $display("FAIL lu_nouse_a got %h exp %h", obs_a(), exp_a()); end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b1, 5'd1, 1'b1, 5'd9, 1'b1);
    checks++;
    if (obs_b() !== exp_b()) begin errors++; $display("FAIL lu_rt_b got %h exp %h", obs_b(), exp_b()); end
  endtask

  task automatic test_mem_wait();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b1, (i == 3), 5'd3, 1'b1, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1);
      checks++;
      if (obs_a() !== exp_a()) begin errors++; $display("FAIL memwait_a cyc %0d got %h exp %h", i, obs_a(), exp_a()); end
      checks++;
      if (obs_b() !== exp_b()) begin errors++; $display("FAIL memwait_b cyc %0d got %h exp %h", i, obs_b(), exp_b()); end
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    checks++;
    if ({pc_wr_a, stall_cnt_a} !== {1'b1, 16'd3}) begin
      errors++; $display("FAIL memwait_cnt got pc %b cnt %0d exp pc 1 cnt 3", pc_wr_a, stall_cnt_a);
    end
  endtask

  task automatic test_timeout();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, (i > 5), 1'b1, (i > 5), 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      checks++;
      if (obs_a() !== exp_a()) begin errors++; $display("FAIL timeout_a cyc %0d got %h exp %h", i, obs_a(), exp_a()); end
      checks++;
      if (obs_b() !== exp_b()) begin errors++; $display("FAIL timeout_b cyc %0d got %h exp %h", i, obs_b(), exp_b()); end
    end
    checks++;
    if ({mem_err_a, pc_wr_a, mem_err_b, pc_wr_b} !== 4'b1001) begin
      errors++; $display("FAIL timeout_halt got err_a %b pc_a %b err_b %b pc_b %b exp 1 0 0 1",
                         mem_err_a, pc_wr_a, mem_err_b, pc_wr_b);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    checks++;
    if ({mem_err_a, stall_cnt_a, pc_wr_a} !== {1'b0, 16'd0, 1'b1}) begin
      errors++; $display("FAIL timeout_clear got err %b cnt %0d pc %b exp 0 0 1", mem_err_a, stall_cnt_a, pc_wr_a);
    end
  endtask

  task automatic test_branch();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 1'b1, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0);
    checks++;
    if ({pc_wr_a, if_id_wr_a, id_ex_wr_a, ex_mem_wr_a, mem_wb_wr_a, if_id_flush_a, id_ex_flush_a} !== EN_BR) begin
      errors++; $display("FAIL br_lu got %h exp %b", obs_a(), EN_BR);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, (i == 2), 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      checks++;
      if (obs_a() !== exp_a()) begin errors++; $display("FAIL br_freeze_a cyc %0d got %h exp %h", i, obs_a(), exp_a()); end
    end
    checks++;
    if ({if_id_flush_a, id_ex_flush_a, pc_wr_a} !== 3'b111) begin
      errors++; $display("FAIL br_deferred got %b exp 111", {if_id_flush_a, id_ex_flush_a, pc_wr_a});
    end
  endtask

  task automatic test_saturation();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd12, 1'b1, 1'b1, 5'd3, 1'b0, 5'd12, 1'b1);
      checks++;
      if (obs_b() !== exp_b()) begin errors++; $display("FAIL sat_b cyc %0d got %h exp %h", i, obs_b(), exp_b()); end
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    checks++;
    if ({stall_cnt_b, stall_cnt_a} !== {3'd7, 16'd10}) begin
      errors++; $display("FAIL sat_cnt got b %0d a %0d exp b 7 a 10", stall_cnt_b, stall_cnt_a);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 99) >= 3), ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) < 4),
            ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      checks++;
      if (obs_a() !== exp_a()) begin errors++; $display("FAIL rand_a cyc %0d got %h exp %h", i, obs_a(), exp_a()); end
      checks++;
      if (obs_b() !== exp_b()) begin errors++; $display("FAIL rand_b cyc %0d got %h exp %h", i, obs_b(), exp_b()); end
    end
  endtask

  initial begin
    rst = 1'b0; br_taken = 1'b0; dm_req = 1'b0; dm_ready = 1'b1; ex_regw = 1'b0;
    ex_mem2r = 1'b0; id_use_rs = 1'b0; id_use_rt = 1'b0; id_rs = '0; id_rt = '0; ex_rd = '0;
    test_reset();
    test_normal();
    test_load_use();
    test_mem_wait();
    test_timeout();
    test_branch();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
